// File: rtl/obstacle_sprite_ram_if.sv
// Bus bundle for obstacle_sprite_ram: CPU Avalon-MM port (s1) and renderer fetch port (s2).
interface obstacle_sprite_ram_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   s1_address;
  logic                s1_chipselect;
  logic                s1_clken;
  logic                s1_read;
  logic                s1_write;
  logic [DATA_W-1:0]   s1_writedata;
  logic [DATA_W/8-1:0] s1_byteenable;
  logic [DATA_W-1:0]   s1_readdata;
  logic                s1_readdatavalid;
  logic                s1_waitrequest;

  logic [ADDR_W-1:0]   s2_address;
  logic                s2_read;
  logic [DATA_W-1:0]   s2_readdata;
  logic                s2_readdatavalid;

  modport master (
    output s1_address, s1_chipselect, s1_clken, s1_read, s1_write,
           s1_writedata, s1_byteenable, s2_address, s2_read,
    input  s1_readdata, s1_readdatavalid, s1_waitrequest,
           s2_readdata, s2_readdatavalid
  );

  modport slave (
    input  s1_address, s1_chipselect, s1_clken, s1_read, s1_write,
           s1_writedata, s1_byteenable, s2_address, s2_read,
    output s1_readdata, s1_readdatavalid, s1_waitrequest,
           s2_readdata, s2_readdatavalid
  );
endinterface

// File: rtl/obstacle_sprite_ram.sv
// Obstacle/sprite RAM: CPU read/write port with byte enables and clock enable,
// renderer read-only port, selectable read latency and a post-reset clear engine.
module obstacle_sprite_ram #(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       DEPTH        = 2048,
  parameter int unsigned       ADDR_W       = 11,
  parameter int unsigned       READ_LATENCY = 1,
  parameter int unsigned       INIT_CLEAR   = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
  input  logic                 clk1_clk,
  input  logic                 reset1_reset,
  input  logic                 reset1_reset_req,
  obstacle_sprite_ram_if.slave bus,
  output logic                 init_busy
);

  localparam int unsigned       NB       = DATA_W / 8;
  localparam int unsigned       MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [MEM_AW-1:0] CNT_LAST = MEM_AW'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e              state_q;
  logic [MEM_AW-1:0]   cnt_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                ready;
  logic                s1_acc;
  logic                s1_rd_acc;
  logic                s1_wr_en;
  logic                s1_in_rng;
  logic                s2_in_rng;
  logic                s2_acc;
  logic [MEM_AW-1:0]   s1_idx;
  logic [MEM_AW-1:0]   s2_idx;

  logic                s1_v1_q, s1_v2_q;
  logic [DATA_W-1:0]   s1_d1_q, s1_d2_q, s1_hold_q;
  logic                s1_last_v;
  logic [DATA_W-1:0]   s1_last_d;

  logic                s2_v1_q, s2_v2_q;
  logic [DATA_W-1:0]   s2_d1_q, s2_d2_q;

  assign ready     = (state_q == ST_READY);
  assign s1_in_rng = ({1'b0, bus.s1_address} < DEPTH_L);
  assign s2_in_rng = ({1'b0, bus.s2_address} < DEPTH_L);
  assign s1_idx    = bus.s1_address[MEM_AW-1:0];
  assign s2_idx    = bus.s2_address[MEM_AW-1:0];

  // Write wins over read when both are requested in the same accepted cycle.
  assign s1_acc    = bus.s1_chipselect & bus.s1_clken & (bus.s1_read | bus.s1_write) & ready;
  assign s1_rd_acc = s1_acc & bus.s1_read & ~bus.s1_write;
  assign s1_wr_en  = s1_acc & bus.s1_write & ~reset1_reset_req & s1_in_rng;
  assign s2_acc    = bus.s2_read & ready;

  // Control FSM: clear sweep after reset, then stays READY until the next reset.
  always_ff @(posedge clk1_clk) begin
    if (reset1_reset) begin
      state_q <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + MEM_AW'(1);
          if (cnt_q == CNT_LAST) state_q <= ST_READY;
        end
        default: ;
      endcase
    end
  end

  assign init_busy          = (state_q == ST_INIT);
  assign bus.s1_waitrequest = (state_q == ST_INIT);

  // Array writes: clear engine while sweeping, byte-lane CPU writes afterwards.
  always_ff @(posedge clk1_clk) begin
    if (!reset1_reset) begin
      if (state_q == ST_INIT) begin
        mem[cnt_q] <= INIT_VALUE;
      end else if (s1_wr_en) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (bus.s1_byteenable[i]) mem[s1_idx][i*8 +: 8] <= bus.s1_writedata[i*8 +: 8];
        end
      end
    end
  end

  assign s1_last_v = (READ_LATENCY == 2) ? s1_v2_q : s1_v1_q;
  assign s1_last_d = (READ_LATENCY == 2) ? s1_d2_q : s1_d1_q;

  // CPU read pipeline; freezes as a whole while clken is low so no response is lost or repeated.
  always_ff @(posedge clk1_clk) begin
    if (reset1_reset) begin
      s1_v1_q   <= 1'b0;
      s1_v2_q   <= 1'b0;
      s1_d1_q   <= '0;
      s1_d2_q   <= '0;
      s1_hold_q <= '0;
    end else if (bus.s1_clken) begin
      s1_v1_q <= s1_rd_acc;
      if (s1_rd_acc) s1_d1_q <= s1_in_rng ? mem[s1_idx] : '0;
      s1_v2_q <= s1_v1_q;
      if (s1_v1_q) s1_d2_q <= s1_d1_q;
      if (s1_last_v) s1_hold_q <= s1_last_d;
    end
  end

  // A frozen response is held back until clken returns; readdata shows the last emitted word meanwhile.
  assign bus.s1_readdatavalid = s1_last_v & bus.s1_clken;
  assign bus.s1_readdata      = bus.s1_readdatavalid ? s1_last_d : s1_hold_q;

  // Renderer read pipeline; data registers load only with a valid word so outputs hold between pulses.
  always_ff @(posedge clk1_clk) begin
    if (reset1_reset) begin
      s2_v1_q <= 1'b0;
      s2_v2_q <= 1'b0;
      s2_d1_q <= '0;
      s2_d2_q <= '0;
    end else begin
      s2_v1_q <= s2_acc;
      if (s2_acc) s2_d1_q <= s2_in_rng ? mem[s2_idx] : '0;
      s2_v2_q <= s2_v1_q;
      if (s2_v1_q) s2_d2_q <= s2_d1_q;
    end
  end

  assign bus.s2_readdatavalid = (READ_LATENCY == 2) ? s2_v2_q : s2_v1_q;
  assign bus.s2_readdata      = (READ_LATENCY == 2) ? s2_d2_q : s2_d1_q;

endmodule

// File: tb/tb_obstacle_sprite_ram.sv
// Testbench for obstacle_sprite_ram: three instances sharing one stimulus stream,
// checked every cycle against a queue-based behavioural model.
module tb_obstacle_sprite_ram;

  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEP_A = 2048;
  localparam int unsigned DEP_B = 1500;
  localparam int unsigned LAT_A = 2;
  localparam int unsigned LAT_B = 1;
  localparam logic [31:0] IV_A  = 32'hDEAD_BEEF;
  localparam logic [31:0] IV_B  = 32'h0BAD_F00D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rreq, cs, clken, rd, wr, s2rd;
  logic [AW-1:0] a1, a2;
  logic [DW-1:0] wd;
  logic [3:0]    be;
  logic          busy_a, busy_b, busy_c;

  obstacle_sprite_ram_if #(.ADDR_W(AW), .DATA_W(DW)) if_a ();
  obstacle_sprite_ram_if #(.ADDR_W(AW), .DATA_W(DW)) if_b ();
  obstacle_sprite_ram_if #(.ADDR_W(AW), .DATA_W(DW)) if_c ();

  assign if_a.s1_address = a1;  assign if_b.s1_address = a1;  assign if_c.s1_address = a1;
  assign if_a.s1_chipselect = cs; assign if_b.s1_chipselect = cs; assign if_c.s1_chipselect = cs;
  assign if_a.s1_clken = clken; assign if_b.s1_clken = clken; assign if_c.s1_clken = clken;
  assign if_a.s1_read = rd;     assign if_b.s1_read = rd;     assign if_c.s1_read = rd;
  assign if_a.s1_write = wr;    assign if_b.s1_write = wr;    assign if_c.s1_write = wr;
  assign if_a.s1_writedata = wd; assign if_b.s1_writedata = wd; assign if_c.s1_writedata = wd;
  assign if_a.s1_byteenable = be; assign if_b.s1_byteenable = be; assign if_c.s1_byteenable = be;
  assign if_a.s2_address = a2;  assign if_b.s2_address = a2;  assign if_c.s2_address = a2;
  assign if_a.s2_read = s2rd;   assign if_b.s2_read = s2rd;   assign if_c.s2_read = s2rd;

  obstacle_sprite_ram #(.DATA_W(DW), .DEPTH(DEP_A), .ADDR_W(AW), .READ_LATENCY(LAT_A),
                        .INIT_CLEAR(1), .INIT_VALUE(IV_A)) dut_a (
    .clk1_clk(clk), .reset1_reset(rst), .reset1_reset_req(rreq), .bus(if_a), .init_busy(busy_a));

  obstacle_sprite_ram #(.DATA_W(DW), .DEPTH(DEP_B), .ADDR_W(AW), .READ_LATENCY(LAT_B),
                        .INIT_CLEAR(1), .INIT_VALUE(IV_B)) dut_b (
    .clk1_clk(clk), .reset1_reset(rst), .reset1_reset_req(rreq), .bus(if_b), .init_busy(busy_b));

  obstacle_sprite_ram #(.DATA_W(DW), .DEPTH(1024), .ADDR_W(AW), .READ_LATENCY(1),
                        .INIT_CLEAR(0), .INIT_VALUE(32'h0)) dut_c (
    .clk1_clk(clk), .reset1_reset(rst), .reset1_reset_req(rreq), .bus(if_c), .init_busy(busy_c));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Behavioural model state, index 0 = dut_a, 1 = dut_b
  logic [31:0] mem_m   [2][2048];
  int unsigned busy_left [2];
  logic [31:0] s1_dat  [2][4];
  int unsigned s1_rem  [2][4];
  int unsigned s1_n    [2];
  logic [31:0] s1_hold [2];
  logic [31:0] s2_dat  [2][4];
  int unsigned s2_due  [2][4];
  int unsigned s2_n    [2];
  logic [31:0] s2_last [2];
  int unsigned cyc    = 0;
  bit          primed = 1'b0;

  logic        sa_v1, sa_v2, sa_wq;
  logic [31:0] sa_d1, sa_d2;

  function automatic int unsigned dep_of(input int unsigned d);
    return (d == 0) ? DEP_A : DEP_B;
  endfunction
  function automatic int unsigned lat_of(input int unsigned d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction
  function automatic logic [31:0] iv_of(input int unsigned d);
    return (d == 0) ? IV_A : IV_B;
  endfunction

  task automatic model_reset(input int unsigned d);
    busy_left[d] = dep_of(d);
    s1_n[d] = 0; s2_n[d] = 0;
    s1_hold[d] = '0; s2_last[d] = '0;
    for (int unsigned i = 0; i < 2048; i++) mem_m[d][i] = iv_of(d);
  endtask

  task automatic sample_dut(input int unsigned d, output logic v1, output logic [31:0] d1,
                            output logic v2, output logic [31:0] d2,
                            output logic bz, output logic wq);
    if (d == 0) begin
      v1 = if_a.s1_readdatavalid; d1 = if_a.s1_readdata;
      v2 = if_a.s2_readdatavalid; d2 = if_a.s2_readdata;
      bz = busy_a; wq = if_a.s1_waitrequest;
    end else begin
      v1 = if_b.s1_readdatavalid; d1 = if_b.s1_readdata;
      v2 = if_b.s2_readdatavalid; d2 = if_b.s2_readdata;
      bz = busy_b; wq = if_b.s1_waitrequest;
    end
  endtask

  task automatic model_check(input int unsigned d);
    logic v1, v2, bz, wq, e1v, e2v;
    logic [31:0] d1, d2, e1d, e2d;
    string p;
    p = (d == 0) ? "a." : "b.";
    sample_dut(d, v1, d1, v2, d2, bz, wq);
    e1v = clken && (s1_n[d] > 0) && (s1_rem[d][0] == 0);
    e1d = e1v ? s1_dat[d][0] : s1_hold[d];
    e2v = (s2_n[d] > 0) && (s2_due[d][0] == cyc);
    e2d = e2v ? s2_dat[d][0] : s2_last[d];
    check({p, "s1_valid"}, v1, e1v);
    check({p, "s1_data"},  d1, e1d);
    check({p, "s2_valid"}, v2, e2v);
    check({p, "s2_data"},  d2, e2d);
    check({p, "init_busy"}, bz, busy_left[d] > 0);
    check({p, "waitreq"},   wq, busy_left[d] > 0);
  endtask

  task automatic model_edge(input int unsigned d);
    bit ready, in1, in2, acc;
    ready = (busy_left[d] == 0);
    in1   = 32'(a1) < dep_of(d);
    in2   = 32'(a2) < dep_of(d);
    acc   = ready && cs && clken && (rd || wr);
    if (s2_n[d] > 0 && s2_due[d][0] == cyc) begin
      s2_last[d] = s2_dat[d][0];
      for (int unsigned i = 1; i < s2_n[d]; i++) begin
        s2_dat[d][i-1] = s2_dat[d][i]; s2_due[d][i-1] = s2_due[d][i];
      end
      s2_n[d]--;
    end
    if (ready && s2rd && s2_n[d] < 4) begin
      s2_dat[d][s2_n[d]] = in2 ? mem_m[d][a2] : 32'h0;
      s2_due[d][s2_n[d]] = cyc + lat_of(d);
      s2_n[d]++;
    end
    if (clken) begin
      if (s1_n[d] > 0 && s1_rem[d][0] == 0) begin
        s1_hold[d] = s1_dat[d][0];
        for (int unsigned i = 1; i < s1_n[d]; i++) begin
          s1_dat[d][i-1] = s1_dat[d][i]; s1_rem[d][i-1] = s1_rem[d][i];
        end
        s1_n[d]--;
      end
      for (int unsigned i = 0; i < s1_n[d]; i++)
        if (s1_rem[d][i] > 0) s1_rem[d][i]--;
      if (acc && rd && !wr && s1_n[d] < 4) begin
        s1_dat[d][s1_n[d]] = in1 ? mem_m[d][a1] : 32'h0;
        s1_rem[d][s1_n[d]] = lat_of(d) - 1;
        s1_n[d]++;
      end
    end
    if (acc && wr && !rreq && in1)
      for (int unsigned b = 0; b < 4; b++)
        if (be[b]) mem_m[d][a1][8*b +: 8] = wd[8*b +: 8];
    if (busy_left[d] > 0) busy_left[d]--;
  endtask

  // One clock cycle: check current outputs, advance the model across the edge, move past the edge.
  task automatic step();
    #1;
    if (primed) begin
      model_check(0);
      model_check(1);
      check("c.init_busy", busy_c, 32'h0);
      check("c.waitreq", if_c.s1_waitrequest, 32'h0);
    end
    sa_v1 = if_a.s1_readdatavalid; sa_d1 = if_a.s1_readdata;
    sa_v2 = if_a.s2_readdatavalid; sa_d2 = if_a.s2_readdata;
    sa_wq = if_a.s1_waitrequest;
    if (rst) begin
      model_reset(0); model_reset(1); primed = 1'b1;
    end else begin
      model_edge(0); model_edge(1);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cs = 1'b0; rd = 1'b0; wr = 1'b0; s2rd = 1'b0; clken = 1'b1; rreq = 1'b0;
    be = 4'hF; wd = '0;
  endtask

  task automatic write_a(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] lanes);
    idle(); cs = 1'b1; wr = 1'b1; a1 = addr; wd = data; be = lanes;
    step();
    idle();
  endtask

  task automatic read_a(input logic [AW-1:0] addr, input logic [31:0] exp, input string tag);
    int unsigned n;
    idle(); cs = 1'b1; rd = 1'b1; a1 = addr;
    step();
    idle();
    n = 0;
    do begin step(); n++; end while (!sa_v1 && n < 8);
    check({tag, ".latency"}, n, LAT_A);
    check({tag, ".data"}, sa_d1, exp);
  endtask

  task automatic wait_init(input string tag);
    int unsigned n;
    n = 0;
    while (busy_a && n < 3000) begin step(); n++; end
    check(tag, n, DEP_A);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned pulses, gap, cnt2, pick;
    logic [31:0] got2 [2];
    idle(); a1 = '0; a2 = '0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    wait_init("init_len");

    read_a(11'd0,    IV_A, "clr0");
    read_a(11'd1023, IV_A, "clr1023");
    read_a(11'd2047, IV_A, "clr2047");

    write_a(11'd5, 32'h1122_3344, 4'b0101);
    read_a(11'd5, 32'hDE22_BE44, "be_merge");

    for (int unsigned i = 0; i < 4; i++) write_a(AW'(i), 32'h100 + i, 4'hF);
    pulses = 0; gap = 0;
    for (int unsigned k = 0; k < 12; k++) begin
      idle();
      if (k < 7) begin cs = 1'b1; rd = 1'b1; end
      case (k)
        0: a1 = 11'd0;
        1: a1 = 11'd1;
        2, 3, 4: begin a1 = 11'd2; clken = 1'b0; end
        5: a1 = 11'd2;
        6: a1 = 11'd3;
        default: ;
      endcase
      step();
      if (sa_v1) begin
        if (!clken) gap++;
        check("b2b.order", sa_d1, 32'h100 + pulses);
        pulses++;
      end
    end
    check("b2b.pulses", pulses, 4);
    check("b2b.gap_valid", gap, 0);

    write_a(11'd7, 32'h0, 4'hF);
    idle(); cs = 1'b1; wr = 1'b1; a1 = 11'd7; wd = 32'hAAAA_5555; s2rd = 1'b1; a2 = 11'd7;
    step();
    idle(); s2rd = 1'b1; a2 = 11'd7;
    step();
    idle();
    cnt2 = 0; got2[0] = 'x; got2[1] = 'x;
    repeat (6) begin
      step();
      if (sa_v2) begin
        if (cnt2 < 2) got2[cnt2] = sa_d2;
        cnt2++;
      end
    end
    check("coll.count", cnt2, 2);
    check("coll.old", got2[0], 32'h0);
    check("coll.new", got2[1], 32'hAAAA_5555);

    idle(); rreq = 1'b1; cs = 1'b1; wr = 1'b1; a1 = 11'd9; wd = 32'h1234_5678;
    step();
    check("rreq.waitreq", sa_wq, 32'h0);
    idle();
    read_a(11'd9, IV_A, "rreq.keep");

    repeat (3000) begin
      cs    = ($urandom_range(0, 4) != 0);
      clken = ($urandom_range(0, 3) != 0);
      rd    = $urandom_range(0, 1) == 1;
      wr    = $urandom_range(0, 2) == 0;
      rreq  = ($urandom_range(0, 9) == 0);
      be    = 4'($urandom);
      wd    = $urandom;
      s2rd  = $urandom_range(0, 1) == 1;
      pick  = $urandom_range(0, 3);
      a1    = (pick == 0) ? AW'($urandom) : (pick == 1) ? AW'(1496 + $urandom_range(0, 7)) : AW'($urandom_range(0, 15));
      pick  = $urandom_range(0, 3);
      a2    = (pick == 0) ? AW'($urandom) : (pick == 1) ? AW'(1496 + $urandom_range(0, 7)) : AW'($urandom_range(0, 15));
      step();
    end
    idle();
    repeat (6) step();

    idle(); cs = 1'b1; rd = 1'b1; a1 = 11'd5; s2rd = 1'b1; a2 = 11'd5;
    step();
    idle(); rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (500) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_init("reinit_len");
    read_a(11'd5, IV_A, "reinit.rd");
    idle();
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
